// File: rtl/pipe_control_unit.sv
// Pipeline control unit: opcode decode, ID/EX -> EX/MEM -> MEM/WB control pipeline,
// load-use stall, branch flush and saturating event counters. Define CTRL_JUMP_EN to add the j instruction.
module pipe_control_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  alu_zero,
    output logic                  ex_reg_write,
    output logic                  ex_reg_dest,
    output logic                  ex_mem_to_reg,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic [1:0]            ex_alu_op,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_reg_write,
    output logic                  mem_mem_to_reg,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  if_flush,
    output logic                  pc_src,
    output logic                  jump,
    output logic                  illegal_op,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef CTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'h02;
`endif

    typedef struct packed {
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } mem_wb_ctrl_t;

    id_ex_ctrl_t           id_ex_q,     id_ex_d;
    ex_mem_ctrl_t          ex_mem_q,    ex_mem_d;
    mem_wb_ctrl_t          mem_wb_q,    mem_wb_d;
    logic [REG_ADDR_W-1:0] ex_rt_q,     ex_rt_d;
    logic                  illegal_q,   illegal_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    id_ex_ctrl_t dec_ctrl;
    logic        dec_legal;
    logic        dec_is_jump;
    logic        load_use;
    logic        branch_taken;

    // Opcode decode; unknown opcodes yield an all-zero bubble.
    always_comb begin
        dec_ctrl    = '0;
        dec_legal   = 1'b1;
        dec_is_jump = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl.reg_dest  = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 2'b10;
            end
            OP_ADDI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            OP_LW: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = 2'b01;
            end
`ifdef CTRL_JUMP_EN
            OP_J: begin
                dec_is_jump = 1'b1;
            end
`endif
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    assign load_use = id_ex_q.mem_read && (ex_rt_q != '0) &&
                      ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
    assign branch_taken = id_ex_q.branch && alu_zero;

    // Hazard steering: branch flush beats load-use stall, which beats jump.
    always_comb begin
        stall    = 1'b0;
        pc_src   = 1'b0;
        jump     = 1'b0;
        if_flush = 1'b0;
        if (!rst) begin
            pc_src   = branch_taken;
            stall    = load_use && !branch_taken;
            jump     = dec_is_jump && !load_use && !branch_taken;
            if_flush = pc_src || jump;
        end
        pc_write   = !stall;
        ifid_write = !stall;
    end

    // Next-state for the control pipeline and counters.
    always_comb begin
        id_ex_d     = dec_ctrl;
        ex_rt_d     = id_rt;
        illegal_d   = !dec_legal;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall || if_flush) begin
            id_ex_d   = '0;
            illegal_d = 1'b0;
        end
        ex_mem_d.mem_read   = id_ex_q.mem_read;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (if_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q     <= '0;
            ex_mem_q    <= '0;
            mem_wb_q    <= '0;
            ex_rt_q     <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            id_ex_q     <= id_ex_d;
            ex_mem_q    <= ex_mem_d;
            mem_wb_q    <= mem_wb_d;
            ex_rt_q     <= ex_rt_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_reg_write   = id_ex_q.reg_write;
    assign ex_reg_dest    = id_ex_q.reg_dest;
    assign ex_mem_to_reg  = id_ex_q.mem_to_reg;
    assign ex_alu_src     = id_ex_q.alu_src;
    assign ex_branch      = id_ex_q.branch;
    assign ex_mem_read    = id_ex_q.mem_read;
    assign ex_mem_write   = id_ex_q.mem_write;
    assign ex_alu_op      = id_ex_q.alu_op;
    assign mem_mem_read   = ex_mem_q.mem_read;
    assign mem_mem_write  = ex_mem_q.mem_write;
    assign mem_reg_write  = ex_mem_q.reg_write;
    assign mem_mem_to_reg = ex_mem_q.mem_to_reg;
    assign wb_reg_write   = mem_wb_q.reg_write;
    assign wb_mem_to_reg  = mem_wb_q.mem_to_reg;
    assign illegal_op     = illegal_q;
    assign stall_count    = stall_cnt_q;
    assign flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Randomized and directed bench for pipe_control_unit against a table-driven pipeline model.
// Honors CTRL_JUMP_EN the same way as the design.
module tb_pipe_control_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;
`ifdef CTRL_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode;
    logic [AW-1:0] id_rs, id_rt;
    logic          alu_zero;
    logic          ex_reg_write, ex_reg_dest, ex_mem_to_reg, ex_alu_src;
    logic          ex_branch, ex_mem_read, ex_mem_write;
    logic [1:0]    ex_alu_op;
    logic          mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
    logic          wb_reg_write, wb_mem_to_reg;
    logic          stall, pc_write, ifid_write, if_flush, pc_src, jump, illegal_op;
    logic [CW-1:0] stall_count, flush_count;

    pipe_control_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
        .alu_zero(alu_zero),
        .ex_reg_write(ex_reg_write), .ex_reg_dest(ex_reg_dest), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
        .pc_src(pc_src), .jump(jump), .illegal_op(illegal_op),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: each pipeline slot holds the 9-bit control word
    // {reg_write, reg_dest, mem_to_reg, alu_src, branch, mem_read, mem_write, alu_op[1:0]}.
    logic [8:0] m_pipe [3];
    int         m_ex_rt;
    bit         m_illegal;
    int         m_stall_cnt, m_flush_cnt;
    localparam int SAT = (1 << CW) - 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_decode(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b1_1_0_0_0_0_0_10;
            6'h08:   return 9'b1_0_0_1_0_0_0_00;
            6'h23:   return 9'b1_0_1_1_0_1_0_00;
            6'h2B:   return 9'b0_0_0_1_0_0_1_00;
            6'h04:   return 9'b0_0_0_0_1_0_0_01;
            default: return 9'b0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h08) || (op == 6'h23) || (op == 6'h2B) ||
               (op == 6'h04) || (JUMP_EN && op == 6'h02);
    endfunction

    function automatic logic [8:0] dut_ex();
        return {ex_reg_write, ex_reg_dest, ex_mem_to_reg, ex_alu_src, ex_branch,
                ex_mem_read, ex_mem_write, ex_alu_op};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '0;
        m_ex_rt = 0; m_illegal = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    // One clock cycle: drive ID inputs, compare everything against the model, advance the model.
    task automatic step(input logic [5:0] op, input int rs, input int rt, input logic z, input logic r);
        bit hz, br, e_stall, e_jump, e_flush;
        logic [8:0] p1, p2;
        @(negedge clk);
        opcode = op; id_rs = AW'(rs); id_rt = AW'(rt); alu_zero = z; rst = r;
        #1;
        p1 = m_pipe[1]; p2 = m_pipe[2];
        hz = m_pipe[0][3] && (m_ex_rt != 0) && (m_ex_rt == rs || m_ex_rt == rt);
        br = m_pipe[0][4] && z;
        e_stall = !r && hz && !br;
        e_jump  = !r && JUMP_EN && (op == 6'h02) && !hz && !br;
        e_flush = !r && (br || e_jump);
        check("ex_ctrl", 32'(dut_ex()), 32'(m_pipe[0]));
        check("mem_ctrl", 32'({mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg}),
              32'({p1[3], p1[2], p1[8], p1[6]}));
        check("wb_ctrl", 32'({wb_reg_write, wb_mem_to_reg}), 32'({p2[8], p2[6]}));
        check("steer", 32'({stall, pc_write, ifid_write, if_flush, pc_src, jump}),
              32'({e_stall, !e_stall, !e_stall, e_flush, !r && br, e_jump}));
        check("illegal_op", 32'(illegal_op), 32'(m_illegal));
        check("stall_count", 32'(stall_count), 32'(m_stall_cnt));
        check("flush_count", 32'(flush_count), 32'(m_flush_cnt));
        if (r) begin
            model_reset();
        end else begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = (e_stall || e_flush) ? 9'b0 : ref_decode(op);
            m_ex_rt   = rt;
            m_illegal = !e_stall && !e_flush && !ref_legal(op);
            if (e_stall && m_stall_cnt < SAT) m_stall_cnt++;
            if (e_flush && m_flush_cnt < SAT) m_flush_cnt++;
        end
    endtask

    logic [5:0] seq_ops [5];
    logic [8:0] seq_ex  [5];
    logic       seq_wb  [5];
    logic [5:0] rnd_ops [7];

    initial begin
        seq_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
        seq_ex  = '{9'b1_1_0_0_0_0_0_10, 9'b1_0_1_1_0_1_0_00, 9'b0_0_0_1_0_0_1_00,
                    9'b0_0_0_0_1_0_0_01, 9'b1_0_0_1_0_0_0_00};
        seq_wb  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rnd_ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};

        rst = 1'b1; opcode = '0; id_rs = '0; id_rt = '0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state, then the basic decode sequence through the whole pipe.
        step(6'h3F, 1, 1, 1'b0, 1'b1);
        check("rst_pc_write", 32'(pc_write), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step((i < 5) ? seq_ops[i] : 6'h00, 0, 0, 1'b0, 1'b0);
            if (i >= 1 && i <= 5) check("seq_ex", 32'(dut_ex()), 32'(seq_ex[i-1]));
            if (i >= 3) check("seq_wb", 32'(wb_reg_write), 32'(seq_wb[i-3]));
        end

        // Load-use hazard with rt=5, then the same with rt=0.
        step(6'h00, 0, 0, 1'b0, 1'b1);
        step(6'h23, 0, 5, 1'b0, 1'b0);
        step(6'h00, 5, 0, 1'b0, 1'b0);
        check("lu_stall", 32'({stall, pc_write, ifid_write}), 32'(3'b100));
        step(6'h00, 5, 0, 1'b0, 1'b0);
        check("lu_bubble", 32'(dut_ex()), 32'd0);
        check("lu_once", 32'(stall), 32'd0);
        check("lu_count", 32'(stall_count), 32'd1);
        step(6'h23, 0, 0, 1'b0, 1'b0);
        step(6'h00, 0, 0, 1'b0, 1'b0);
        check("lu_rt0", 32'(stall), 32'd0);

        // Taken branch in EX.
        step(6'h00, 0, 0, 1'b0, 1'b1);
        step(6'h04, 1, 2, 1'b0, 1'b0);
        step(6'h00, 1, 2, 1'b1, 1'b0);
        check("br_flush", 32'({pc_src, if_flush, stall}), 32'(3'b110));
        step(6'h00, 0, 0, 1'b0, 1'b0);
        check("br_count", 32'(flush_count), 32'd1);
        check("br_bubble", 32'(dut_ex()), 32'd0);

        // Illegal opcode.
        step(6'h3F, 0, 0, 1'b0, 1'b0);
        step(6'h00, 0, 0, 1'b0, 1'b0);
        check("ill_ex", 32'(dut_ex()), 32'd0);
        check("ill_flag", 32'(illegal_op), 32'd1);
        step(6'h00, 0, 0, 1'b0, 1'b0);
        check("ill_once", 32'(illegal_op), 32'd0);

        // Jump opcode.
        step(6'h00, 0, 0, 1'b0, 1'b1);
        step(6'h02, 0, 0, 1'b0, 1'b0);
`ifdef CTRL_JUMP_EN
        check("j_steer", 32'({jump, if_flush}), 32'(2'b11));
`else
        check("j_steer", 32'({jump, if_flush}), 32'(2'b00));
`endif
        step(6'h00, 0, 0, 1'b0, 1'b0);
`ifdef CTRL_JUMP_EN
        check("j_illegal", 32'(illegal_op), 32'd0);
`else
        check("j_illegal", 32'(illegal_op), 32'd1);
`endif

        // Stall counter saturation, then reset mid-stream.
        step(6'h00, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step(6'h23, 0, 5, 1'b0, 1'b0);
            step(6'h00, 5, 0, 1'b0, 1'b0);
        end
        step(6'h23, 0, 5, 1'b0, 1'b0);
        check("sat_count", 32'(stall_count), 32'(SAT));
        step(6'h04, 5, 5, 1'b0, 1'b1);
        step(6'h00, 0, 0, 1'b0, 1'b0);
        check("rst_regs", 32'({dut_ex(), mem_mem_read, mem_mem_write, mem_reg_write,
                               mem_mem_to_reg, wb_reg_write, wb_mem_to_reg, illegal_op}), 32'd0);
        check("rst_counts", 32'({stall_count, flush_count}), 32'd0);

        // Randomized traffic with small register numbers to make hazards frequent.
        for (int i = 0; i < 600; i++) begin
            int k;
            logic [5:0] op;
            k = int'($urandom_range(0, 7));
            op = (k == 7) ? 6'($urandom) : rnd_ops[k];
            step(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5: register-address width of the rs/rt fields.
REQ-002 Parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 opcode  input  6  ID-stage instruction[31:26].
REQ-006 id_rs, id_rt  input  REG_ADDR_W each  ID-stage source register fields.
REQ-007 alu_zero  input  1  EX-stage ALU zero flag.
REQ-008 ex_reg_write, ex_reg_dest, ex_mem_to_reg, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write  output  1 each  ID/EX control register.
REQ-009 ex_alu_op  output  2  ID/EX ALU-op field.
REQ-010 mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg  output  1 each  EX/MEM control register.
REQ-011 wb_reg_write, wb_mem_to_reg  output  1 each  MEM/WB control register.
REQ-012 stall, pc_write, ifid_write, if_flush, pc_src, jump  output  1 each  combinational hazard and steering outputs.
REQ-013 illegal_op  output  1  registered one-cycle flag for an undecodable opcode.
REQ-014 stall_count, flush_count  output  CNT_W each  saturating event counters.

Function
REQ-015 Decode opcode 0x00 (R-type): reg_dest=1, reg_write=1, alu_src=0, alu_op=10, all other controls 0.
REQ-016 Decode opcode 0x08 (addi): reg_write=1, alu_src=1, alu_op=00, all other controls 0.
REQ-017 Decode opcode 0x23 (lw): reg_write=1, alu_src=1, mem_read=1, mem_to_reg=1, alu_op=00, all other controls 0.
REQ-018 Decode opcode 0x2B (sw): mem_write=1, alu_src=1, alu_op=00, all other controls 0.
REQ-019 Decode opcode 0x04 (beq): branch=1, alu_op=01, all other controls 0.
REQ-020 Any other opcode (see REQ-036) decodes to an all-zero bubble, and illegal_op is 1 in the following cycle.
REQ-021 The decoded controls enter the ID/EX register with 1-cycle latency; EX/MEM and MEM/WB each add 1 cycle, so wb_* lags decode by 3 cycles.
REQ-022 The block holds ex_rt, an internal copy of id_rt registered alongside the ID/EX controls.
REQ-023 Load-use hazard: stall=1 when ex_mem_read=1, ex_rt!=0 and (ex_rt==id_rs or ex_rt==id_rt).
REQ-024 While stall=1: pc_write=0, ifid_write=0, and the ID/EX register loads a bubble.
REQ-025 pc_src = ex_branch AND alu_zero; if_flush=1 whenever pc_src=1, and the ID/EX register loads a bubble on that edge.
REQ-026 Priority: branch flush > load-use stall > jump. When a flush and a stall coincide, stall is forced to 0 and pc_write=1.
REQ-027 pc_write=1 and ifid_write=1 whenever stall=0.
REQ-028 stall_count increments on each cycle with stall=1; flush_count increments on each cycle with if_flush=1; both saturate at 2^CNT_W-1 and never wrap.
REQ-029 EX/MEM and MEM/WB always advance; bubbles propagate through them as all-zero controls.

Reset
REQ-030 With rst=1 at a clock edge, every ID/EX, EX/MEM and MEM/WB control bit, ex_rt, illegal_op, stall_count and flush_count is cleared to 0.
REQ-031 A reset mid-operation discards all in-flight controls; the first decode after rst deasserts appears on the ex_* outputs one cycle later.
REQ-032 While rst=1, the combinational outputs follow the cleared state: stall=0, pc_src=0, if_flush=0, jump=0, pc_write=1, ifid_write=1.

Configuration
REQ-033 Macro CTRL_JUMP_EN compiles in support for the j instruction.
REQ-034 With CTRL_JUMP_EN defined, opcode 0x02 in ID sets jump=1 and if_flush=1 combinationally and sends a bubble into ID/EX.
REQ-035 A jump is suppressed (jump=0) when a stall or a branch flush is active in the same cycle, and it increments flush_count.
REQ-036 Without CTRL_JUMP_EN, opcode 0x02 is illegal per REQ-020 and jump is tied to 0.

Verification
REQ-037 Reset, then opcode sequence 0x00, 0x23, 0x2B, 0x04, 0x08 -> ex_* controls match REQ-015..019 one cycle after each, and wb_reg_write reads 1,1,0,0,1 three cycles after each.
REQ-038 lw with rt=5, then an instruction with id_rs=5 -> stall=1, pc_write=0, ifid_write=0 for exactly 1 cycle, a bubble in ID/EX, and stall_count=1; the same sequence with rt=0 -> no stall.
REQ-039 beq in EX with alu_zero=1 while ID holds a hazard-causing instruction -> pc_src=1, if_flush=1, stall=0, flush_count=1.
REQ-040 Opcode 0x3F -> all ex_* outputs 0, with illegal_op=1 for one cycle.
REQ-041 Force 2^CNT_W+3 stall cycles (CNT_W=4 build) -> stall_count holds at 15; then assert rst mid-stream -> all registered outputs 0 on the next edge.
REQ-042 Opcode 0x02 -> jump=1 and if_flush=1 with CTRL_JUMP_EN defined; without the macro, illegal_op=1 and jump=0.
